lcd_char_refresh: RTL and testbench
===================================

// Module: lcd_char_refresh
// PURPOSE
//  Downstream consumer of the stopwatch character source. Sweeps a 5-bit character
//  index 0..31, samples the returned ASCII byte, and writes it to a 16x2 HD44780 LCD
//  over an 8-bit, write-only bus. Runs the power-up init sequence, then refreshes both
//  lines continuously with no per-frame clear, so the display does not flicker.
// PARAMETERS
//  CLK_HZ     50_000_000  clk frequency; US = CLK_HZ/1_000_000 cycles per microsecond
//  T_PWR_US   20000       wait after reset release before the first command
//  T_CMD_US   50          execute wait after every command/data write except clear
//  T_CLR_US   2000        execute wait after clear (0x01)
//  T_SU_CYC   4           RS/DATA setup cycles, E low, before E rises
//  T_E_CYC    12          E high width in cycles; also E-low hold cycles after the fall
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-low reset
//  char_in     in   8  ASCII for the current index; upstream registers it one clk later
//  index       out  5  character position: 0-15 line 1, 16-31 line 2
//  lcd_e       out  1  LCD enable strobe
//  lcd_rs      out  1  0 = command, 1 = data
//  lcd_rw      out  1  tied 0 (write only)
//  lcd_data    out  8  LCD data bus
//  frame_done  out  1  one-cycle pulse after the write of char 31 completes
// BEHAVIOUR
//  - Reset (async assert, any state): index=0, lcd_e=0, lcd_rs=0, lcd_rw=0,
//    lcd_data=8'h00, frame_done=0, FSM=PWR_WAIT, all timers cleared. Reset mid-write
//    drops E at once; after release the full init sequence runs again.
//  - FSM: PWR_WAIT -> INIT(0x38, 0x0C, 0x06, 0x01) -> ADDR(0x80) -> CHAR x16
//    -> ADDR(0xC0) -> CHAR x16 -> frame_done -> ADDR(0x80) ...
//    INIT issues one command per write; the next write starts only after the previous
//    write's execute wait expires.
//  - Write cycle, owned by the sub-module:
//    * SETUP, T_SU_CYC cycles: RS/DATA driven, E=0.
//    * E_HI, T_E_CYC cycles: E=1.
//    * HOLD, T_E_CYC cycles: E=0, RS/DATA held.
//    * EXEC: T_CMD_US*US cycles, or T_CLR_US*US cycles for 0x01.
//    RS and DATA stay constant from SETUP start to HOLD end.
//  - Char fetch: index updates at least 2 clk before SETUP of that char. char_in is
//    captured at the start of SETUP, and that byte is the one written. index stays
//    stable for the entire write.
//  - index increments after each CHAR write and wraps 31 -> 0 with frame_done=1 for
//    exactly one cycle. ADDR writes do not advance index.
//  - Width rules: timers are $clog2(T_PWR_US*US+1) bits wide. Timer compares are
//    >= terminal-1, so a 1-cycle parameter gives exactly 1 cycle.
//  - lcd_rs=1 only for CHAR writes; 0 for INIT and ADDR.
//  - No busy-flag polling; timing is open-loop only.
// STRUCTURE
//  - Package lcd_pkg: command constants
//    LCD_FUNC_8B2L=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY_INC=8'h06, LCD_CLEAR=8'h01,
//    LCD_LINE1=8'h80, LCD_LINE2=8'hC0; plus the top FSM state encoding.
//  - Sub-module lcd_bus_write. Inputs: start, rs_in, byte_in, long_wait.
//    Outputs: busy, done (1-cycle pulse), lcd_e, lcd_rs, lcd_data.
//    The top sequencer issues start only when busy=0.
// TESTING (CLK_HZ=1_000_000, T_PWR_US=100, T_CMD_US=5, T_CLR_US=20, T_SU_CYC=2,
//          T_E_CYC=3; bench model returns char_in = {3'b010, index} one clk late)
//  1 Release reset -> no E rise for 100 cycles; then E pulses with DATA 38, 0C, 06, 01,
//    80 in order; the gap after 01 is >= 20 cycles; every E-high width is 3 cycles.
//  2 First frame -> 32 data writes with RS=1, DATA = 8'h40+index for index 0..31;
//    DATA 0xC0 with RS=0 between index 15 and 16; frame_done pulses once after 31.
//  3 Wrap -> after frame_done: one 0x80 write, then index=0. Frame 2 contains no
//    0x01 and no init commands.
//  4 Change model char_in every clk -> the captured byte equals the model output for
//    the held index; DATA/RS never change while E=1 or during HOLD.
//  5 Assert rst while E=1 mid-frame -> E=0, index=0, data=0 asynchronously;
//    after release, scenario 1 repeats exactly.
//  6 Hold rst for 3 frames' worth of cycles -> all outputs remain at reset values.

Source files
------------

// File: rtl/lcd_pkg.sv
// Purpose: HD44780 command bytes and FSM encodings shared by the LCD refresh block.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;  // auto-increment, no shift
    localparam logic [7:0] LCD_CLEAR     = 8'h01;  // clear display, needs long execute wait
    localparam logic [7:0] LCD_LINE1     = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LCD_LINE2     = 8'hC0;  // DDRAM address 0x40

    // Top sequencer: each write is a GO state (issue start) followed by a WT state (await done).
    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_GO,
        ST_INIT_WT,
        ST_ADDR_GO,
        ST_ADDR_WT,
        ST_FETCH,
        ST_CHAR_GO,
        ST_CHAR_WT
    } top_state_t;

    // Single bus write: setup, E pulse, hold, then open-loop execute wait.
    typedef enum logic [2:0] {
        BW_IDLE,
        BW_SETUP,
        BW_E_HI,
        BW_HOLD,
        BW_EXEC
    } bw_state_t;

    // Power-up command list, issued in step order 0..3.
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    init_cmd = LCD_FUNC_8B2L;
            2'd1:    init_cmd = LCD_DISP_ON;
            2'd2:    init_cmd = LCD_ENTRY_INC;
            default: init_cmd = LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_write.sv
// Purpose: one HD44780 write (SETUP/E_HI/HOLD/EXEC); ports clk, rst, start, rs_in, byte_in,
//          long_wait -> busy, done, lcd_e, lcd_rs, lcd_data.
// Latency: SU_CYC + 2*E_CYC + CMD_CYC (or CLR_CYC) cycles from start to the done pulse.
// Backpressure: start is only honoured while busy=0; RS/DATA are latched on start and held.
module lcd_bus_write
    import lcd_pkg::*;
#(
    parameter int TW      = 8,
    parameter int SU_CYC  = 4,
    parameter int E_CYC   = 12,
    parameter int CMD_CYC = 50,
    parameter int CLR_CYC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] byte_in,
    input  logic       long_wait,
    output logic       busy,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    // Compares use terminal-1 so a 1-cycle parameter yields exactly one cycle.
    localparam logic [TW-1:0] SU_LAST  = TW'(SU_CYC - 1);
    localparam logic [TW-1:0] E_LAST   = TW'(E_CYC - 1);
    localparam logic [TW-1:0] CMD_LAST = TW'(CMD_CYC - 1);
    localparam logic [TW-1:0] CLR_LAST = TW'(CLR_CYC - 1);

    bw_state_t     state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          long_q, long_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BW_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            long_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            long_q  <= long_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        rs_d    = rs_q;
        data_d  = data_q;
        long_d  = long_q;
        done_d  = 1'b0;
        case (state_q)
            BW_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    // The byte is captured here and held untouched until the next start.
                    state_d = BW_SETUP;
                    rs_d    = rs_in;
                    data_d  = byte_in;
                    long_d  = long_wait;
                end
            end
            BW_SETUP: if (cnt_q >= SU_LAST) begin
                state_d = BW_E_HI;
                cnt_d   = '0;
            end
            BW_E_HI: if (cnt_q >= E_LAST) begin
                state_d = BW_HOLD;
                cnt_d   = '0;
            end
            BW_HOLD: if (cnt_q >= E_LAST) begin
                state_d = BW_EXEC;
                cnt_d   = '0;
            end
            BW_EXEC: if (cnt_q >= (long_q ? CLR_LAST : CMD_LAST)) begin
                state_d = BW_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = BW_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q != BW_IDLE);
        done     = done_q;
        lcd_e    = (state_q == BW_E_HI);
        lcd_rs   = rs_q;
        lcd_data = data_q;
    end

endmodule

// File: rtl/lcd_char_refresh.sv
// Purpose: init a 16x2 HD44780, then endlessly rewrite 32 chars fetched by index (no clear);
//          ports clk, rst, char_in -> index, lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done.
// Latency: power-up wait, then one bus write per char; char_in sampled 2 clk after index moves.
// Backpressure: none upstream; writes are paced open-loop by lcd_bus_write busy/done.
module lcd_char_refresh
    import lcd_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int T_PWR_US = 20000,
    parameter int T_CMD_US = 50,
    parameter int T_CLR_US = 2000,
    parameter int T_SU_CYC = 4,
    parameter int T_E_CYC  = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       frame_done
);

    localparam int            US       = CLK_HZ / 1_000_000;
    localparam int            TW       = $clog2(T_PWR_US * US + 1);
    localparam logic [TW-1:0] PWR_LAST = TW'(T_PWR_US * US - 1);

    top_state_t    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    step_q, step_d;
    logic [4:0]    index_q, index_d;
    logic          frame_done_q, frame_done_d;

    logic          wr_start, wr_rs, wr_long, wr_busy, wr_done;
    logic [7:0]    wr_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_PWR_WAIT;
            tmr_q        <= '0;
            step_q       <= 2'd0;
            index_q      <= 5'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            step_q       <= step_d;
            index_q      <= index_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        step_d       = step_q;
        index_d      = index_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_PWR_WAIT: begin
                if (tmr_q >= PWR_LAST) begin
                    state_d = ST_INIT_GO;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_INIT_GO: if (!wr_busy) state_d = ST_INIT_WT;
            ST_INIT_WT: if (wr_done) begin
                if (step_q == 2'd3) begin
                    state_d = ST_ADDR_GO;
                end else begin
                    step_d  = step_q + 2'd1;
                    state_d = ST_INIT_GO;
                end
            end
            ST_ADDR_GO: if (!wr_busy) state_d = ST_ADDR_WT;
            ST_ADDR_WT: if (wr_done) state_d = ST_FETCH;
            // index moved at the previous edge; upstream registers char_in one clk later,
            // so the start issued from CHAR_GO samples a byte that matches index.
            ST_FETCH:   state_d = ST_CHAR_GO;
            ST_CHAR_GO: if (!wr_busy) state_d = ST_CHAR_WT;
            ST_CHAR_WT: if (wr_done) begin
                index_d      = index_q + 5'd1;
                frame_done_d = (index_q == 5'd31);
                // After char 15 or 31 the cursor must be re-addressed to the next line.
                state_d      = (index_q[3:0] == 4'hF) ? ST_ADDR_GO : ST_FETCH;
            end
            default: state_d = ST_PWR_WAIT;
        endcase
    end

    always_comb begin
        wr_start = 1'b0;
        wr_rs    = 1'b0;
        wr_byte  = 8'h00;
        wr_long  = 1'b0;
        case (state_q)
            ST_INIT_GO: begin
                wr_start = !wr_busy;
                wr_byte  = init_cmd(step_q);
                wr_long  = (init_cmd(step_q) == LCD_CLEAR);
            end
            ST_ADDR_GO: begin
                wr_start = !wr_busy;
                wr_byte  = index_q[4] ? LCD_LINE2 : LCD_LINE1;
            end
            ST_CHAR_GO: begin
                wr_start = !wr_busy;
                wr_rs    = 1'b1;
                wr_byte  = char_in;
            end
            default: ;
        endcase
    end

    lcd_bus_write #(
        .TW      (TW),
        .SU_CYC  (T_SU_CYC),
        .E_CYC   (T_E_CYC),
        .CMD_CYC (T_CMD_US * US),
        .CLR_CYC (T_CLR_US * US)
    ) u_bus_write (
        .clk       (clk),
        .rst       (rst),
        .start     (wr_start),
        .rs_in     (wr_rs),
        .byte_in   (wr_byte),
        .long_wait (wr_long),
        .busy      (wr_busy),
        .done      (wr_done),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_data  (lcd_data)
    );

    assign index      = index_q;
    assign frame_done = frame_done_q;
    assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_char_refresh.sv
// Purpose: directed self-checking bench for lcd_char_refresh with a one-clk-late char source.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_char_refresh;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    logic       frame_done;

    logic [2:0] char_hi = 3'b010;
    int         errors  = 0;
    int         checks  = 0;
    int         fd_cnt  = 0;

    always #5 clk = ~clk;

    lcd_char_refresh #(
        .CLK_HZ   (1_000_000),
        .T_PWR_US (100),
        .T_CMD_US (5),
        .T_CLR_US (20),
        .T_SU_CYC (2),
        .T_E_CYC  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .index      (index),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .frame_done (frame_done)
    );

    // Upstream character source: registered one clk after index.
    always @(posedge clk) char_in <= {char_hi, index};

    // Counts cycles with frame_done high, so a stretched pulse shows up as an extra count.
    always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Waits for the next E rise, checks the written byte, E width and RS/DATA/index stability
    // over E high plus the 3 hold cycles. Returns at the last hold sample.
    task automatic do_write(input string tag, input logic [7:0] exp_d, input logic exp_rs,
                            input logic [4:0] exp_idx, input int min_gap);
        int         gap;
        int         width;
        int         bad;
        logic [7:0] d;
        logic       r;
        logic [4:0] ix;
        gap = 0;
        while (lcd_e !== 1'b1 && gap < 400) begin
            @(negedge clk);
            gap++;
        end
        if (lcd_e !== 1'b1) begin
            chk({tag, "_timeout"}, {31'd0, lcd_e}, 32'd1);
            return;
        end
        d     = lcd_data;
        r     = lcd_rs;
        ix    = index;
        width = 0;
        bad   = 0;
        while (lcd_e === 1'b1 && width < 50) begin
            if (lcd_data !== d || lcd_rs !== r || index !== ix) bad++;
            @(negedge clk);
            width++;
        end
        for (int k = 0; k < 3; k++) begin
            if (lcd_data !== d || lcd_rs !== r || index !== ix || lcd_e !== 1'b0) bad++;
            if (k < 2) @(negedge clk);
        end
        chk({tag, "_data"},   {24'd0, d},  {24'd0, exp_d});
        chk({tag, "_rs"},     {31'd0, r},  {31'd0, exp_rs});
        chk({tag, "_index"},  {27'd0, ix}, {27'd0, exp_idx});
        chk({tag, "_ewidth"}, width,       32'd3);
        chk({tag, "_stable"}, bad,         32'd0);
        chk({tag, "_gap"},    {31'd0, (gap >= min_gap)}, 32'd1);
    endtask

    task automatic check_init(input string tag);
        do_write({tag, "_38"}, 8'h38, 1'b0, 5'd0, 100);
        do_write({tag, "_0C"}, 8'h0C, 1'b0, 5'd0, 5);
        do_write({tag, "_06"}, 8'h06, 1'b0, 5'd0, 5);
        do_write({tag, "_01"}, 8'h01, 1'b0, 5'd0, 5);
        do_write({tag, "_80"}, 8'h80, 1'b0, 5'd0, 20);
    endtask

    // One full frame of 32 chars plus the wrap-around line-1 address write.
    task automatic check_frame(input string tag, input logic [2:0] hi, input int fd_before);
        logic [4:0] ii;
        for (int i = 0; i < 32; i++) begin
            ii = 5'(i);
            if (i == 16) do_write({tag, "_C0"}, 8'hC0, 1'b0, 5'd16, 5);
            do_write($sformatf("%s_ch%0d", tag, i), {hi, ii}, 1'b1, ii, 5);
        end
        chk({tag, "_fd_pre"}, fd_cnt, fd_before);
        do_write({tag, "_wrap80"}, 8'h80, 1'b0, 5'd0, 5);
        chk({tag, "_fd_post"}, fd_cnt, fd_before + 1);
    endtask

    initial begin
        int bad;
        int n;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_index", {27'd0, index},    32'd0);
        chk("rst_e",     {31'd0, lcd_e},    32'd0);
        chk("rst_rs",    {31'd0, lcd_rs},   32'd0);
        chk("rst_rw",    {31'd0, lcd_rw},   32'd0);
        chk("rst_data",  {24'd0, lcd_data}, 32'd0);
        chk("rst_fd",    {31'd0, frame_done}, 32'd0);

        rst = 1'b1;
        check_init("s1");
        check_frame("f1", 3'b010, 0);

        // Different source pattern for frame 2; still no init or clear commands expected.
        char_hi = 3'b011;
        check_frame("f2", 3'b011, 1);

        char_hi = 3'b010;
        for (int i = 0; i < 5; i++) begin
            do_write($sformatf("f3_ch%0d", i), {3'b010, 5'(i)}, 1'b1, 5'(i), 5);
        end

        // Reset in the middle of an E-high phase must act without waiting for a clock.
        n = 0;
        while (lcd_e !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_e_seen", {31'd0, lcd_e}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_e",     {31'd0, lcd_e},      32'd0);
        chk("async_index", {27'd0, index},      32'd0);
        chk("async_data",  {24'd0, lcd_data},   32'd0);
        chk("async_rs",    {31'd0, lcd_rs},     32'd0);
        chk("async_fd",    {31'd0, frame_done}, 32'd0);

        bad = 0;
        repeat (1800) begin
            @(negedge clk);
            if (index !== 5'd0 || lcd_e !== 1'b0 || lcd_rs !== 1'b0 || lcd_rw !== 1'b0 ||
                lcd_data !== 8'h00 || frame_done !== 1'b0) bad++;
        end
        chk("rst_hold", bad, 32'd0);

        rst = 1'b1;
        check_init("s5");
        do_write("s5_ch0", 8'h40, 1'b1, 5'd0, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
